// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/DM single-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data memory.
// One transaction at a time; DM has priority, with a starvation guard for IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (LAT < 1 || LAT > 7) begin : g_lat_chk
            $fatal(1, "mem_port_arbiter: LAT must be in 1..7");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_chk
            $fatal(1, "mem_port_arbiter: STARVE_MAX must be in 1..15");
        end
    endgenerate

    localparam logic [2:0] LAT_INIT   = 3'(LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [2:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              force_if;

    assign force_if = (starve_q == STARVE_LIM) && if_req;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                // Grants are combinational, so gate them while reset is held.
                if (rst) begin
                    if (dm_req && !force_if) begin
                        dm_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        if (dm_we) begin
                            dm_valid_d = 1'b1;
                        end else begin
                            state_d = RD_WAIT;
                            lat_d   = LAT_INIT;
                            owner_d = OWN_DM;
                        end
                        if (!if_req)
                            starve_d = '0;
                        else if (starve_q != STARVE_LIM)
                            starve_d = starve_q + 4'd1;
                    end else if (if_req) begin
                        if_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                        state_d  = RD_WAIT;
                        lat_d    = LAT_INIT;
                        owner_d  = OWN_IF;
                        starve_d = '0;
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d = IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        dm_rdata_d = mem_rdata;
                        dm_valid_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            lat_q      <= '0;
            starve_q   <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_valid = if_valid_q;
    assign dm_valid = dm_valid_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign busy     = (state_q == RD_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed corner sequences, a vector table and
// randomized traffic checked against a cycle-count transaction model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 64 words, read data appears LAT cycles after the command,
    // junk on mem_rdata in every other cycle.
    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    logic        mem_load;
    logic [31:0] tb_mem [64];
    logic [31:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    always_ff @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? tb_mem[mem_addr[7:2]] : $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    int n_chk;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_load = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        rst = 1'b1;
    endtask

    typedef struct {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic        e_if_gnt;
        logic        e_dm_gnt;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_busy;
        logic        e_if_valid;
        logic        e_dm_valid;
    } vec_t;

    vec_t vt [9];

    // Random-phase model state
    int          cyc, free_at, ifv_at, dmv_at, starve;
    logic        dm_rd_pend, e_if, e_dm, e_free, force_if;
    logic [31:0] ref_mem [64];
    logic [31:0] pend_if, pend_dm, exp_if_rdata, exp_dm_rdata;
    logic [31:0] e_addr, e_wdata;
    logic [31:0] w;

    initial begin
        n_chk = 0;
        n_fail = 0;

        // Reset held with both requesters active: everything quiet.
        rst = 1'b0; mem_load = 1'b1;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'h55;
        step();
        #1;
        chk_b("rst_if_gnt", if_gnt, 1'b0);
        chk_b("rst_dm_gnt", dm_gnt, 1'b0);
        chk_b("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_if_valid", if_valid, 1'b0);
        chk_b("rst_dm_valid", dm_valid, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        step();
        mem_load = 1'b0;
        rst = 1'b1;
        #1;
        chk_b("rel_dm_gnt", dm_gnt, 1'b1);
        chk_b("rel_if_gnt", if_gnt, 1'b0);
        chk("rel_mem_addr", mem_addr, 32'h200);
        step();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (LAT + 2) step();

        // IF read of 0xDEADBEEF at 0x40 (word placed there by a DM write).
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        #1;
        chk_b("wr40_dm_gnt", dm_gnt, 1'b1);
        step();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk_b("ifrd_gnt_t", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        #1;
        chk_b("ifrd_busy_t1", busy, 1'b1);
        chk_b("ifrd_valid_t1", if_valid, 1'b0);
        step();
        chk_b("ifrd_busy_t2", busy, 1'b1);
        chk_b("ifrd_valid_t2", if_valid, 1'b0);
        step();
        chk_b("ifrd_valid_t3", if_valid, 1'b1);
        chk("ifrd_rdata_t3", if_rdata, 32'hDEAD_BEEF);
        chk_b("ifrd_busy_t3", busy, 1'b0);
        step();
        chk_b("ifrd_valid_t4", if_valid, 1'b0);
        chk("ifrd_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Simultaneous reads: DM first, IF granted as dm_valid pulses.
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        #1;
        chk_b("sim_dm_gnt", dm_gnt, 1'b1);
        chk_b("sim_if_gnt", if_gnt, 1'b0);
        step();
        dm_req = 1'b0;
        #1;
        chk_b("sim_if_wait1", if_gnt, 1'b0);
        step();
        chk_b("sim_if_wait2", if_gnt, 1'b0);
        step();
        chk_b("sim_dm_valid", dm_valid, 1'b1);
        chk("sim_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        chk_b("sim_if_gnt_at_valid", if_gnt, 1'b1);
        chk("sim_if_mem_addr", mem_addr, 32'h44);
        step();
        if_req = 1'b0;
        repeat (LAT + 2) step();

        // Reset in the middle of a read drops it.
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk_b("mid_if_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        #1;
        chk_b("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk_b("mid_busy_rst", busy, 1'b0);
        chk("mid_if_rdata_rst", if_rdata, 32'h0);
        step();
        rst = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            #1;
            chk_b("mid_no_if_valid", if_valid, 1'b0);
            chk_b("mid_no_dm_valid", dm_valid, 1'b0);
            chk_b("mid_idle", busy, 1'b0);
            chk("mid_if_rdata", if_rdata, 32'h0);
            step();
        end

        // Vector table: write burst, starvation guard, grant at valid.
        vt[0] = '{1, 1, 1, 32'h100, 0, 1, 1, 32'h100, 0, 0, 0};
        vt[1] = '{1, 1, 1, 32'h104, 0, 1, 1, 32'h104, 0, 0, 1};
        vt[2] = '{1, 1, 1, 32'h108, 0, 1, 1, 32'h108, 0, 0, 1};
        vt[3] = '{1, 1, 1, 32'h10C, 0, 1, 1, 32'h10C, 0, 0, 1};
        vt[4] = '{1, 1, 1, 32'h110, 1, 0, 0, 32'h080, 0, 0, 1};
        vt[5] = '{0, 1, 1, 32'h110, 0, 0, 0, 32'h000, 1, 0, 0};
        vt[6] = '{0, 1, 1, 32'h110, 0, 0, 0, 32'h000, 1, 0, 0};
        vt[7] = '{0, 1, 1, 32'h110, 0, 1, 1, 32'h110, 0, 1, 0};
        vt[8] = '{0, 0, 0, 32'h000, 0, 0, 0, 32'h000, 0, 0, 1};
        do_reset();
        if_addr = 32'h80;
        for (int r = 0; r < 9; r++) begin
            if_req = vt[r].if_req; dm_req = vt[r].dm_req;
            dm_we = vt[r].dm_we; dm_addr = vt[r].dm_addr; dm_wdata = 32'(r);
            #1;
            chk_b($sformatf("vec%0d_if_gnt", r), if_gnt, vt[r].e_if_gnt);
            chk_b($sformatf("vec%0d_dm_gnt", r), dm_gnt, vt[r].e_dm_gnt);
            chk_b($sformatf("vec%0d_mem_en", r), mem_en, vt[r].e_if_gnt | vt[r].e_dm_gnt);
            chk_b($sformatf("vec%0d_mem_we", r), mem_we, vt[r].e_mem_we);
            chk($sformatf("vec%0d_mem_addr", r), mem_addr, vt[r].e_mem_addr);
            chk_b($sformatf("vec%0d_busy", r), busy, vt[r].e_busy);
            chk_b($sformatf("vec%0d_if_valid", r), if_valid, vt[r].e_if_valid);
            chk_b($sformatf("vec%0d_dm_valid", r), dm_valid, vt[r].e_dm_valid);
            step();
        end

        // Randomized traffic against the transaction model.
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        cyc = 0; free_at = 0; ifv_at = -1; dmv_at = -1; starve = 0;
        dm_rd_pend = 1'b0; pend_if = '0; pend_dm = '0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        e_if = 1'b0; e_dm = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (e_if) if_req = 1'b0;
            if (e_dm) dm_req = 1'b0;
            if (!if_req && $urandom_range(0, 99) < 50) begin
                if_req = 1'b1;
                w = $urandom;
                if_addr = {24'h0, w[7:2], 2'b00};
            end
            if (!dm_req && $urandom_range(0, 99) < 75) begin
                dm_req = 1'b1;
                dm_we = $urandom_range(0, 1) == 1;
                w = $urandom;
                dm_addr = {24'h0, w[7:2], 2'b00};
                dm_wdata = $urandom;
            end
            #1;
            e_free = cyc >= free_at;
            force_if = (starve == SM) && if_req;
            e_dm = e_free && dm_req && !force_if;
            e_if = e_free && !e_dm && if_req;
            e_addr = e_dm ? dm_addr : (e_if ? if_addr : 32'h0);
            e_wdata = e_dm ? dm_wdata : 32'h0;
            if (cyc == ifv_at) exp_if_rdata = pend_if;
            if (cyc == dmv_at && dm_rd_pend) exp_dm_rdata = pend_dm;
            chk_b("rnd_if_gnt", if_gnt, e_if);
            chk_b("rnd_dm_gnt", dm_gnt, e_dm);
            chk_b("rnd_mem_en", mem_en, e_if | e_dm);
            chk_b("rnd_mem_we", mem_we, e_dm & dm_we);
            chk("rnd_mem_addr", mem_addr, e_addr);
            chk("rnd_mem_wdata", mem_wdata, e_wdata);
            chk_b("rnd_busy", busy, !e_free);
            chk_b("rnd_if_valid", if_valid, cyc == ifv_at);
            chk_b("rnd_dm_valid", dm_valid, cyc == dmv_at);
            chk("rnd_if_rdata", if_rdata, exp_if_rdata);
            chk("rnd_dm_rdata", dm_rdata, exp_dm_rdata);
            if (e_dm) begin
                if (dm_we) begin
                    ref_mem[dm_addr[7:2]] = dm_wdata;
                    dm_rd_pend = 1'b0;
                    dmv_at = cyc + 1;
                    free_at = cyc + 1;
                end else begin
                    pend_dm = ref_mem[dm_addr[7:2]];
                    dm_rd_pend = 1'b1;
                    dmv_at = cyc + LAT + 1;
                    free_at = cyc + LAT + 1;
                end
                starve = if_req ? ((starve < SM) ? starve + 1 : SM) : 0;
            end else if (e_if) begin
                pend_if = ref_mem[if_addr[7:2]];
                ifv_at = cyc + LAT + 1;
                free_at = cyc + LAT + 1;
                starve = 0;
            end else if (e_free) begin
                starve = 0;
            end
            cyc++;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
